alu_arbiter: RTL and testbench

Arbitrates shared access to the single multicycle-datapath ALU between two requesters, e.g. port 0 = main datapath ops and port 1 = PC/branch-target computation. The arbiter accepts one operation at a time through a request/done handshake and picks the requester by round-robin. It registers the operands into the ALU's Sel/A/B inputs, captures the ALU's C and ZeroFlag, and returns them to the winning requester. It sits between the control unit and the ALU instance.

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multicycle ALU between two requesters.
// Optional macro ALU_ARB_MUL_WAIT_EN stretches EXEC to MUL_CYCLES for multiply (Sel 4'b0010).
module alu_arbiter #(
   parameter int unsigned WORD_LENGTH = 32,
   parameter int unsigned MUL_CYCLES  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req0,
   input  logic                   req1,
   input  logic [3:0]             sel0,
   input  logic [3:0]             sel1,
   input  logic [WORD_LENGTH-1:0] a0,
   input  logic [WORD_LENGTH-1:0] b0,
   input  logic [WORD_LENGTH-1:0] a1,
   input  logic [WORD_LENGTH-1:0] b1,
   output logic                   done0,
   output logic                   done1,
   output logic [WORD_LENGTH-1:0] result,
   output logic                   zero,
   output logic                   busy,
   output logic [3:0]             alu_sel,
   output logic [WORD_LENGTH-1:0] alu_a,
   output logic [WORD_LENGTH-1:0] alu_b,
   input  logic [WORD_LENGTH-1:0] alu_c,
   input  logic                   alu_zero
);

   if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
      $error("MUL_CYCLES must be in 1..15");
   end

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e                 state_q, state_d;
   logic                   owner_q, owner_d;
   logic                   last_q, last_d;
   logic [3:0]             sel_q, sel_d;
   logic [WORD_LENGTH-1:0] a_q, a_d;
   logic [WORD_LENGTH-1:0] b_q, b_d;
   logic [WORD_LENGTH-1:0] result_q, result_d;
   logic                   zero_q, zero_d;
   logic                   done0_q, done0_d;
   logic                   done1_q, done1_d;
   logic                   gnt;
   logic [3:0]             gnt_sel;
   logic                   exec_last;
`ifdef ALU_ARB_MUL_WAIT_EN
   logic [3:0]             cnt_q, cnt_d;
`endif

   // On a tie the port that was not served last wins.
   assign gnt     = (req0 && req1) ? ~last_q : req1;
   assign gnt_sel = gnt ? sel1 : sel0;

`ifdef ALU_ARB_MUL_WAIT_EN
   assign exec_last = (cnt_q == 4'd0);
`else
   assign exec_last = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      sel_d    = sel_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      zero_d   = zero_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
`ifdef ALU_ARB_MUL_WAIT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               owner_d = gnt;
               sel_d   = gnt_sel;
               a_d     = gnt ? a1 : a0;
               b_d     = gnt ? b1 : b0;
`ifdef ALU_ARB_MUL_WAIT_EN
               cnt_d   = (gnt_sel == 4'b0010) ? 4'(MUL_CYCLES - 1) : 4'd0;
`endif
               state_d = StExec;
            end
         end
         StExec: begin
            if (exec_last) begin
               result_d = alu_c;
               zero_d   = alu_zero;
               done0_d  = ~owner_q;
               done1_d  = owner_q;
               state_d  = StResp;
            end
`ifdef ALU_ARB_MUL_WAIT_EN
            else begin
               cnt_d = cnt_q - 4'd1;
            end
`endif
         end
         StResp: begin
            last_d  = owner_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         sel_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
`ifdef ALU_ARB_MUL_WAIT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         sel_q    <= sel_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
`ifdef ALU_ARB_MUL_WAIT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign done0   = done0_q;
   assign done1   = done1_q;
   assign result  = result_q;
   assign zero    = zero_q;
   assign busy    = (state_q != StIdle);
   assign alu_sel = sel_q;
   assign alu_a   = a_q;
   assign alu_b   = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
   localparam int W = 32;
`ifdef ALU_ARB_MUL_WAIT_EN
   localparam int MulLat = 4;
`else
   localparam int MulLat = 2;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [3:0]   sel0 = '0, sel1 = '0;
   logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         done0, done1, zero, busy, alu_zero;
   logic [W-1:0] result, alu_a, alu_b, alu_c;
   logic [3:0]   alu_sel;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.WORD_LENGTH(W), .MUL_CYCLES(3)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .sel0(sel0), .sel1(sel1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .done0(done0), .done1(done1), .result(result), .zero(zero), .busy(busy),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
      .alu_c(alu_c), .alu_zero(alu_zero)
   );

   always #5 clk = ~clk;

   // Behavioural ALU; unknown codes yield 0.
   always_comb begin
      alu_c = '0;
      case (alu_sel)
         4'b0000: alu_c = alu_a + alu_b;
         4'b0001: alu_c = alu_a - alu_b;
         4'b0010: alu_c = alu_a[15:0] * alu_b[15:0];
         4'b0100: alu_c = alu_a & alu_b;
         4'b0110: alu_c = alu_a | alu_b;
         4'b0111: alu_c = alu_a ^ alu_b;
         default: alu_c = '0;
      endcase
      alu_zero = (alu_c == '0);
   end

   typedef struct {
      bit         port;
      logic [3:0] sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic       zf;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Issue one request, wait for its done; req is dropped in the done cycle.
   task automatic do_op(input bit port, input logic [3:0] sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat, output int busy_cnt,
                        output bit other_seen, output logic [3:0] xsel,
                        output logic [W-1:0] xa, output logic [W-1:0] xb);
      bit got;
      got = 1'b0; lat = 0; busy_cnt = 0; other_seen = 1'b0;
      xsel = '0; xa = '0; xb = '0;
      if (port) begin sel1 = sel; a1 = a; b1 = b; req1 = 1'b1; end
      else      begin sel0 = sel; a0 = a; b0 = b; req0 = 1'b1; end
      while (!got && lat < 20) begin
         tick();
         lat++;
         if (busy) busy_cnt++;
         if (lat == 1) begin xsel = alu_sel; xa = alu_a; xb = alu_b; end
         if (port ? done0 : done1) other_seen = 1'b1;
         if (port ? done1 : done0) got = 1'b1;
      end
      if (!got) lat = -1;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   initial begin
      int lat, bcnt, n, cyc;
      bit other, seen;
      logic [3:0] xs;
      logic [W-1:0] xa, xb;
      int ev_port[4];
      int ev_cyc[4];

      vecs[0] = '{1'b0, 4'b0000, 32'd5,        32'd7,        32'd12,     1'b0};
      vecs[1] = '{1'b1, 4'b0001, 32'd9,        32'd9,        32'd0,      1'b1};
      vecs[2] = '{1'b0, 4'b0110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};
      vecs[3] = '{1'b1, 4'b0100, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00, 1'b0};
      vecs[4] = '{1'b0, 4'b0111, 32'h0000_AAAA, 32'h0000_AAAA, 32'd0,      1'b1};
      vecs[5] = '{1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd1,        32'd0,      1'b1};
      vecs[6] = '{1'b0, 4'b1111, 32'd3,        32'd4,        32'd0,      1'b1};

      do_reset();
      chk("rst_done0", 32'(done0), 32'd0);
      chk("rst_done1", 32'(done1), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_alu_sel", 32'(alu_sel), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);

      tick();
      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].port, vecs[i].sel, vecs[i].a, vecs[i].b, lat, bcnt, other, xs, xa, xb);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("v%0d_result", i), result, vecs[i].res);
         chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zf));
         chk($sformatf("v%0d_other_done", i), 32'(other), 32'd0);
         chk($sformatf("v%0d_exec_sel", i), 32'(xs), 32'(vecs[i].sel));
         chk($sformatf("v%0d_exec_a", i), xa, vecs[i].a);
         chk($sformatf("v%0d_exec_b", i), xb, vecs[i].b);
         chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd2);
         tick();
         chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
         chk($sformatf("v%0d_done_cleared", i), 32'(done0 | done1), 32'd0);
         chk($sformatf("v%0d_result_held", i), result, vecs[i].res);
         chk($sformatf("v%0d_alu_a_held", i), alu_a, vecs[i].a);
      end

      // Tie straight after reset: port 0 first, then port 1.
      do_reset();
      sel0 = 4'b0001; a0 = 32'd9;    b0 = 32'd9;
      sel1 = 4'b0110; a1 = 32'h00F0; b1 = 32'h000F;
      req0 = 1'b1; req1 = 1'b1;
      n = 0; seen = 1'b0;
      while (!done0 && n < 20) begin
         tick();
         n++;
         if (done1) seen = 1'b1;
      end
      req0 = 1'b0;
      chk("tie_p0_latency", 32'(n), 32'd2);
      chk("tie_p1_early", 32'(seen), 32'd0);
      chk("tie_p0_result", result, 32'd0);
      chk("tie_p0_zero", 32'(zero), 32'd1);
      n = 0;
      while (!done1 && n < 20) begin
         tick();
         n++;
      end
      req1 = 1'b0;
      chk("tie_p1_spacing", 32'(n), 32'd3);
      chk("tie_p1_result", result, 32'h0000_00FF);
      chk("tie_p1_zero", 32'(zero), 32'd0);
      tick();

      // Both held continuously: grants alternate, done every 3 cycles.
      sel0 = 4'b0000; a0 = 32'd1; b0 = 32'd1;
      sel1 = 4'b0000; a1 = 32'd2; b1 = 32'd2;
      req0 = 1'b1; req1 = 1'b1;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 40) begin
         tick();
         cyc++;
         if (done0 || done1) begin
            ev_port[n] = done1 ? 1 : 0;
            ev_cyc[n]  = cyc;
            n++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_count", 32'(n), 32'd4);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("rr_port%0d", i), 32'(ev_port[i]), 32'(i % 2));
         if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(ev_cyc[i] - ev_cyc[i-1]), 32'd3);
      end
      tick();
      tick();

      // Multiply on port 1.
      do_op(1'b1, 4'b0010, 32'd300, 32'd200, lat, bcnt, other, xs, xa, xb);
      chk("mul_latency", 32'(lat), 32'(MulLat));
      chk("mul_busy_cycles", 32'(bcnt), 32'(MulLat));
      chk("mul_result", result, 32'd60000);
      chk("mul_other_done", 32'(other), 32'd0);
      tick();
      chk("mul_idle_busy", 32'(busy), 32'd0);

      // Reset during EXEC aborts and restores last so the next tie goes to port 0.
      do_op(1'b0, 4'b0000, 32'd1, 32'd2, lat, bcnt, other, xs, xa, xb);
      chk("pre_abort_result", result, 32'd3);
      tick();
      sel0 = 4'b0000; a0 = 32'd10; b0 = 32'd20; req0 = 1'b1;
      tick();
      chk("abort_in_exec", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0 = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_alu_a", alu_a, 32'd0);
      chk("abort_done0", 32'(done0), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done0 || done1) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      sel0 = 4'b0000; a0 = 32'd4; b0 = 32'd4;
      sel1 = 4'b0000; a1 = 32'd8; b1 = 32'd8;
      req0 = 1'b1; req1 = 1'b1;
      n = 0;
      while (!(done0 || done1) && n < 20) begin
         tick();
         n++;
      end
      chk("abort_tie_port0", 32'(done0), 32'd1);
      chk("abort_tie_result", result, 32'd8);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
